// File: rtl/fetch_seq_ctrl.sv
// Sequential instruction fetch controller: issues a pc to instruction memory, captures the word
// and presents it to the decoder. Optional `FETCH_PERF_CNT_EN adds a 16-bit saturating fetch_count.
module fetch_seq_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              instr_ready,
  input  logic [DATA_W-1:0] iram_q,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DATA  = 3'd2,
    OUT   = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              load_instr;
  logic              handshake;
  logic              start_accept;

  // Decoder handshake: instr_valid is high only in OUT; a transfer happens on a rising edge where
  // instr_valid && instr_ready. instr/instr_pc never change while instr_valid is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= START_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_instr) begin
        instr    <= iram_q;
        instr_pc <= pc;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    load_instr   = 1'b0;
    handshake    = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          start_accept = 1'b1;
          pc_nxt       = START_PC;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (jump_en) begin
          pc_nxt    = jump_addr;
          state_nxt = ISSUE;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        // A redirect here drops the in-flight word before it is ever presented.
        if (jump_en) begin
          pc_nxt    = jump_addr;
          state_nxt = ISSUE;
        end else begin
          load_instr = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (instr_ready) begin
          handshake = 1'b1;
          pc_nxt    = jump_en ? jump_addr : pc + ADDR_W'(1);
          if ((instr[DATA_W-1 -: 4] == 4'hF) && !jump_en) state_nxt = HALT;
          else                                            state_nxt = ISSUE;
        end else if (jump_en) begin
          pc_nxt    = jump_addr;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign iram_addr   = pc;
  assign instr_valid = (state == OUT);
  assign busy        = (state == ISSUE) || (state == DATA) || (state == OUT);
  assign halted      = (state == HALT);
  assign state_dbg   = state;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start_accept) begin
      cnt <= '0;
    end else if (handshake && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign fetch_count = cnt;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: expected {pc, instr} pairs are queued by the stimulus and
// popped by a monitor on every decoder handshake; timing and reset behaviour are checked inline.
module tb_fetch_seq_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_DATA = 3'd2, S_OUT = 3'd3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              jump_en = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              instr_ready = 1'b1;
  logic [DATA_W-1:0] iram_q = '0;
  logic [ADDR_W-1:0] iram_addr;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              busy;
  logic              halted;
  logic [2:0]        state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       fetch_count;
`endif

  logic [DATA_W-1:0]        mem [256];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  fetch_seq_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr_ready (instr_ready),
    .iram_q      (iram_q),
    .iram_addr   (iram_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .busy        (busy),
    .halted      (halted),
    .state_dbg   (state_dbg)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  // clock / reset block and synchronous instruction memory
  always #5 clock = ~clock;

  always @(posedge clock) iram_q <= mem[iram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait expired (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: compare on every handshake.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_hs: got pc=%0h instr=%0h, expected no handshake", instr_pc, instr);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("hs_pc", 32'(instr_pc), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("hs_instr", 32'(instr), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic expect_word(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] w);
    exp_q.push_back({pc, w});
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (instr_valid !== 1'b1 && n < 20);
    if (instr_valid !== 1'b1) timeout(name);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (state_dbg !== s && n < 20);
    if (state_dbg !== s) timeout(name);
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (halted !== 1'b1 && n < 40);
    if (halted !== 1'b1) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h5678;
    mem[8'h02] = 16'hF000;
    mem[8'h10] = 16'h2222;
    mem[8'h40] = 16'hABCD;
    mem[8'h41] = 16'h1111;
    mem[8'hFF] = 16'h3333;

    // reset state
    repeat (3) @(posedge clock);
    #2;
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_addr", 32'(iram_addr), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_wait_valid", 32'(instr_valid), 32'h0);
    chk("idle_wait_busy", 32'(busy), 32'h0);

    // start latency and 3-cycle throughput
    expect_word(8'h00, 16'h1234);
    expect_word(8'h01, 16'h5678);
    expect_word(8'h02, 16'hF000);
    pulse_start();
    @(negedge clock); chk("lat_c1_valid", 32'(instr_valid), 32'h0);
    chk("lat_c1_busy", 32'(busy), 32'h1);
    @(negedge clock); chk("lat_c2_valid", 32'(instr_valid), 32'h0);
    @(negedge clock); chk("lat_c3_valid", 32'(instr_valid), 32'h1);
    chk("lat_c3_instr", 32'(instr), 32'h1234);
    chk("lat_c3_pc", 32'(instr_pc), 32'h00);
    @(negedge clock); chk("thr_c4_valid", 32'(instr_valid), 32'h0);
    @(negedge clock); chk("thr_c5_valid", 32'(instr_valid), 32'h0);
    @(negedge clock); chk("thr_c6_valid", 32'(instr_valid), 32'h1);
    chk("thr_c6_instr", 32'(instr), 32'h5678);
    chk("thr_c6_pc", 32'(instr_pc), 32'h01);

    // halt opcode, frozen address, jump ignored while halted
    wait_halted("halt1");
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_addr", 32'(iram_addr), 32'h03);
    @(posedge clock); #1 jump_en = 1'b1; jump_addr = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("halt_hold_addr", 32'(iram_addr), 32'h03);
      chk("halt_hold", 32'(halted), 32'h1);
    end
    @(posedge clock); #1 jump_en = 1'b0;

    // restart from HALT, stall in OUT for 5 cycles
    expect_word(8'h00, 16'h1234);
    @(posedge clock); #1 start = 1'b1; instr_ready = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_instr", 32'(instr), 32'h1234);
      chk("stall_pc", 32'(instr_pc), 32'h00);
      chk("stall_addr", 32'(iram_addr), 32'h00);
    end
    instr_ready = 1'b1;

    // handshake with jump to 0x40
    expect_word(8'h01, 16'h5678);
    expect_word(8'h40, 16'hABCD);
    wait_valid("pre_jump_valid");
    jump_en = 1'b1; jump_addr = 8'h40;
    @(posedge clock); #1 jump_en = 1'b0;

    // jump while in DATA of 0x41: word 0x1111 is discarded
    expect_word(8'h10, 16'h2222);
    wait_valid("at_40_valid");
    wait_state(S_DATA, "at_41_data");
    jump_en = 1'b1; jump_addr = 8'h10;
    @(posedge clock); #1 jump_en = 1'b0;

    // handshake jump to 0xFF, then wrap to 0x00 and halt at 0x02
    expect_word(8'hFF, 16'h3333);
    expect_word(8'h00, 16'h1234);
    expect_word(8'h01, 16'h5678);
    expect_word(8'h02, 16'hF000);
    wait_valid("at_10_valid");
    jump_en = 1'b1; jump_addr = 8'hFF;
    @(posedge clock); #1 jump_en = 1'b0;
    wait_halted("halt2");
    chk("halt2_addr", 32'(iram_addr), 32'h03);

    // three handshakes after a clearing start
    expect_word(8'h00, 16'h1234);
    expect_word(8'h01, 16'h5678);
    expect_word(8'h02, 16'hF000);
    pulse_start();
    wait_halted("halt3");
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count_3", 32'(fetch_count), 32'd3);
`endif

    // asynchronous reset during DATA
    pulse_start();
    wait_state(S_DATA, "abort_data");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_pc", 32'(instr_pc), 32'h0);
    chk("arst_addr", 32'(iram_addr), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fetch_count", 32'(fetch_count), 32'd0);
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst_valid", 32'(instr_valid), 32'h0);
      chk("post_rst_state", 32'(state_dbg), 32'(S_IDLE));
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
